// File: rtl/arc4_prga_encrypt.sv
// ARC4 PRGA encrypt engine: reads length-prefixed pt, permutes S in place, writes length-prefixed ct.
// Define ARC4_DROP_EN to discard DROP_BYTES keystream bytes before the first message byte.
module arc4_prga_encrypt #(
  parameter int unsigned MSG_MAX    = 255,
  parameter int unsigned DROP_BYTES = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic [7:0] ct_addr,
  output logic [7:0] ct_wrdata,
  output logic       ct_wren
);

`ifdef ARC4_DROP_EN
  localparam bit DropEn = 1'b1;
`else
  localparam bit DropEn = 1'b0;
`endif

  localparam logic [7:0]  MsgMax   = 8'(MSG_MAX);
  localparam logic [15:0] DropLast = 16'(DROP_BYTES - 1);

  typedef enum logic [3:0] {
    IDLE, RD_LEN, WR_LEN, INC_I, WAIT_SI, CALC_J, WAIT_SJ,
    WR_SI, WR_SJ, RD_PAD, WAIT_PAD, WR_CT, DONE
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  i, j, k, len, si, sj, pad, pt_q;
  logic [7:0]  len_c;
  logic        dropping;
  logic [15:0] drop_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      len      <= '0;
      si       <= '0;
      sj       <= '0;
      pad      <= '0;
      pt_q     <= '0;
      dropping <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        WR_LEN: begin
          len      <= len_c;
          k        <= 8'd1;
          i        <= '0;
          j        <= '0;
          dropping <= DropEn && (DROP_BYTES != 0) && (len_c != 8'd0);
          drop_cnt <= '0;
        end
        INC_I:   i  <= i + 8'd1;
        WAIT_SI: si <= s_rddata;
        CALC_J:  j  <= j + si;
        WAIT_SJ: sj <= s_rddata;
        WR_SJ: begin
          if (dropping) begin
            if (drop_cnt == DropLast) dropping <= 1'b0;
            else                      drop_cnt <= drop_cnt + 16'd1;
          end
        end
        WAIT_PAD: begin
          pad  <= s_rddata;
          pt_q <= pt_rddata;
        end
        WR_CT: if (k != len) k <= k + 8'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    len_c = (pt_rddata > MsgMax) ? MsgMax : pt_rddata;
  end

  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    pt_addr   = '0;
    ct_addr   = '0;
    ct_wrdata = '0;
    ct_wren   = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        rdy = 1'b1;
        if (en) state_nxt = RD_LEN;
      end
      RD_LEN: state_nxt = WR_LEN;
      WR_LEN: begin
        ct_wrdata = len_c;
        ct_wren   = 1'b1;
        state_nxt = (len_c == 8'd0) ? DONE : INC_I;
      end
      INC_I: begin
        s_addr    = i + 8'd1;
        state_nxt = WAIT_SI;
      end
      WAIT_SI: state_nxt = CALC_J;
      CALC_J: begin
        s_addr    = j + si;
        state_nxt = WAIT_SJ;
      end
      WAIT_SJ: state_nxt = WR_SI;
      WR_SI: begin
        s_addr    = i;
        s_wrdata  = sj;
        s_wren    = 1'b1;
        state_nxt = WR_SJ;
      end
      WR_SJ: begin
        s_addr    = j;
        s_wrdata  = si;
        s_wren    = 1'b1;
        pt_addr   = dropping ? 8'd0 : k;
        state_nxt = dropping ? INC_I : RD_PAD;
      end
      // pt_addr held through WAIT_PAD so pt[k] is valid whether or not the RAM holds q
      RD_PAD: begin
        s_addr    = si + sj;
        pt_addr   = k;
        state_nxt = WAIT_PAD;
      end
      WAIT_PAD: begin
        pt_addr   = k;
        state_nxt = WR_CT;
      end
      WR_CT: begin
        ct_addr   = k;
        ct_wrdata = pt_q ^ pad;
        ct_wren   = 1'b1;
        state_nxt = (k == len) ? DONE : INC_I;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_arc4_prga_encrypt.sv
// Self-checking bench for arc4_prga_encrypt: RAM models plus a software RC4 reference.
module tb_arc4_prga_encrypt;

`ifdef ARC4_DROP_EN
  localparam int unsigned DROP = 256;
`else
  localparam int unsigned DROP = 0;
`endif
  localparam int unsigned MSG_MAX = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata;
  logic       s_wren;
  logic [7:0] pt_addr, pt_rddata;
  logic [7:0] ct_addr, ct_wrdata;
  logic       ct_wren;

  arc4_prga_encrypt #(.MSG_MAX(MSG_MAX), .DROP_BYTES(256)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata),
    .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0, n_pass = 0;
  logic [7:0]  s_mem[256], s_init[256], pt_mem[256], ct_mem[256], model_s[256], key_s[256];
  logic [7:0]  ks[256];
  logic        load_s = 1'b0;
  int unsigned ct_wr_cnt = 0;
  logic [15:0] exp_q[$];
  bit          cmp_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  // Memories with registered read
  always @(posedge clk) begin
    if (load_s) begin
      for (int x = 0; x < 256; x++) s_mem[x] <= s_init[x];
    end else if (s_wren) begin
      s_mem[s_addr] <= s_wrdata;
    end
    s_rddata  <= s_mem[s_addr];
    pt_rddata <= pt_mem[pt_addr];
    if (ct_wren) begin
      ct_mem[ct_addr] <= ct_wrdata;
      ct_wr_cnt <= ct_wr_cnt + 1;
    end
  end

  // Output compare process
  always @(negedge clk) begin
    if (cmp_on) begin
      if (rdy) chk("idle_no_write", {s_wren, ct_wren}, 2'b00);
      if (ct_wren) begin
        if (exp_q.size() == 0) chk("ct_unexpected_write", {ct_addr, ct_wrdata}, 16'hxxxx);
        else chk("ct_write", {ct_addr, ct_wrdata}, exp_q.pop_front());
      end
    end
  end

  task automatic ksa_compute(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2);
    logic [7:0] key[3];
    logic [7:0] t;
    int unsigned jj = 0;
    key[0] = k0; key[1] = k1; key[2] = k2;
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    for (int x = 0; x < 256; x++) begin
      jj = (jj + s_init[x] + key[x % 3]) % 256;
      t = s_init[x]; s_init[x] = s_init[jj]; s_init[jj] = t;
    end
  endtask

  task automatic identity_compute();
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
  endtask

  task automatic load_s_ram();
    model_s = s_init;
    key_s   = s_init;
    load_s = 1'b1;
    @(negedge clk);
    load_s = 1'b0;
  endtask

  task automatic set_pt(input int unsigned n);
    pt_mem[0] = 8'(n);
    for (int x = 1; x < 256; x++) pt_mem[x] = 8'($urandom);
  endtask

  // Plain RC4 PRGA on model_s, fresh i=j=0, optional dropN
  task automatic keystream(input int unsigned n);
    int unsigned ii = 0, jj = 0;
    logic [7:0] t;
    for (int unsigned step = 0; step < DROP + n; step++) begin
      ii = (ii + 1) % 256;
      jj = (jj + model_s[ii]) % 256;
      t = model_s[ii]; model_s[ii] = model_s[jj]; model_s[jj] = t;
      if (step >= DROP) ks[step - DROP + 1] = model_s[(model_s[ii] + model_s[jj]) % 256];
    end
  endtask

  task automatic model_run();
    int unsigned n;
    n = (pt_mem[0] > MSG_MAX) ? MSG_MAX : pt_mem[0];
    exp_q.push_back({8'h00, 8'(n)});
    if (n != 0) begin
      keystream(n);
      for (int unsigned x = 1; x <= n; x++) exp_q.push_back({8'(x), pt_mem[x] ^ ks[x]});
    end
  endtask

  task automatic recover();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic wait_rdy(output int cyc);
    cyc = 0;
    while (!rdy && cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    if (!rdy) begin
      chk("rdy_timeout", 1'b0, 1'b1);
      recover();
    end
  endtask

  // Called at a negedge with rdy=1
  task automatic run(input bit hold, output int cyc);
    model_run();
    en = 1'b1;
    @(negedge clk);
    if (!hold) en = 1'b0;
    chk("rdy_fall", rdy, 1'b0);
    wait_rdy(cyc);
  endtask

  task automatic post_run();
    int unsigned bad = 0;
    chk("exp_drained", exp_q.size(), 0);
    for (int x = 0; x < 256; x++) if (s_mem[x] !== model_s[x]) bad++;
    chk("s_final", bad, 0);
  endtask

  initial begin
    int cyc;
    int unsigned snap, bad, n;
    logic [7:0] saved[256];

    for (int x = 0; x < 256; x++) ct_mem[x] = 8'h00;
    identity_compute();
    set_pt(0);
    repeat (3) @(negedge clk);
    chk("rst_rdy", rdy, 1'b1);
    chk("rst_outs", {s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren}, 64'h0);
    rst_n = 1'b1;
    load_s_ram();
    cmp_on = 1'b1;

    // Identity S, pt = 02 'A' 'B'
    identity_compute();
    load_s_ram();
    pt_mem[0] = 8'h02; pt_mem[1] = 8'h41; pt_mem[2] = 8'h42;
`ifndef ARC4_DROP_EN
    saved = model_s;
    model_run();
    chk("model_pin_ct1", exp_q[1], 16'h0143);
    chk("model_pin_ct2", exp_q[2], 16'h0247);
    exp_q.delete();
    model_s = saved;
`endif
    run(1'b0, cyc);
    post_run();
`ifndef ARC4_DROP_EN
    chk("lit_ct0", ct_mem[0], 8'h02);
    chk("lit_ct1", ct_mem[1], 8'h43);
    chk("lit_ct2", ct_mem[2], 8'h47);
    chk("lit_s2", s_mem[2], 8'h03);
    chk("lit_s3", s_mem[3], 8'h02);
`endif

    // Zero-length message
    set_pt(0);
    snap = ct_wr_cnt;
    run(1'b0, cyc);
    chk("len0_write_count", ct_wr_cnt - snap, 1);
    chk("len0_ct0", ct_mem[0], 8'h00);
    chk("len0_latency_le4", (cyc + 1) <= 4, 1'b1);
    post_run();

    // Identity S, single byte (dropN golden when drop is enabled)
    identity_compute();
    load_s_ram();
    set_pt(1);
    run(1'b0, cyc);
    post_run();

    // KSA key 000018, 40-byte message, then decrypt round trip
    ksa_compute(8'h00, 8'h00, 8'h18);
    load_s_ram();
    set_pt(40);
    run(1'b0, cyc);
    post_run();
    saved = model_s;
    model_s = key_s;
    keystream(40);
    bad = 0;
    for (int x = 1; x <= 40; x++) if ((ct_mem[x] ^ ks[x]) !== pt_mem[x]) bad++;
    chk("decrypt_roundtrip", bad, 0);
    model_s = saved;

    // en held high across three back-to-back runs on the mutated S
    foreach (saved[x]) saved[x] = 8'h00;
    for (int r = 0; r < 3; r++) begin
      set_pt((r == 1) ? 1 : 5 + 7 * r);
      run(1'b1, cyc);
      post_run();
    end
    en = 1'b0;
    snap = ct_wr_cnt;
    repeat (4) @(negedge clk);
    chk("no_run_after_en_drop", ct_wr_cnt - snap, 0);

    // Reset during the per-byte loop
    identity_compute();
    load_s_ram();
    set_pt(20);
    model_run();
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (60) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    snap = ct_wr_cnt;
    chk("abort_rdy", rdy, 1'b1);
    chk("abort_wren", {s_wren, ct_wren}, 2'b00);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("abort_no_more_writes", ct_wr_cnt - snap, 0);
    identity_compute();
    load_s_ram();
    set_pt(20);
    run(1'b0, cyc);
    post_run();

    // Randomised runs, including the 255-byte boundary and chained runs without re-KSA
    for (int r = 0; r < 6; r++) begin
      if (r % 2 == 0) begin
        ksa_compute(8'($urandom), 8'($urandom), 8'($urandom));
        load_s_ram();
      end
      n = (r == 0) ? 255 : (r == 3) ? 1 : $urandom_range(2, 254);
      set_pt(n);
      run(1'b0, cyc);
      post_run();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
